// File: rtl/axi_lite_arbiter.sv
// 2:1 AXI-Lite arbiter: IFU read port (M0) and LSU read/write port (M1) share one slave port.
// Exactly one transaction is in flight at a time. The grant is held from the address request
// until the response handshake.
// Optional feature: define AXI_ARB_RR_EN for round-robin contention resolution.
// The default build uses fixed priority, where M1 always wins.
module axi_lite_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // M0 (IFU), read only
    input  logic              m0_ar_valid_i,
    input  logic [ADDR_W-1:0] m0_ar_addr_i,
    output logic              m0_ar_ready_o,
    output logic              m0_r_valid_o,
    output logic [DATA_W-1:0] m0_r_data_o,
    output logic [1:0]        m0_r_resp_o,
    input  logic              m0_r_ready_i,
    // M1 (LSU)
    input  logic              m1_ar_valid_i,
    input  logic [ADDR_W-1:0] m1_ar_addr_i,
    output logic              m1_ar_ready_o,
    output logic              m1_r_valid_o,
    output logic [DATA_W-1:0] m1_r_data_o,
    output logic [1:0]        m1_r_resp_o,
    input  logic              m1_r_ready_i,
    input  logic              m1_aw_valid_i,
    input  logic [ADDR_W-1:0] m1_aw_addr_i,
    output logic              m1_aw_ready_o,
    input  logic              m1_w_valid_i,
    input  logic [DATA_W-1:0] m1_w_data_i,
    input  logic [STRB_W-1:0] m1_w_strb_i,
    output logic              m1_w_ready_o,
    output logic              m1_b_valid_o,
    output logic [1:0]        m1_b_resp_o,
    input  logic              m1_b_ready_i,
    // Slave port
    output logic              s_ar_valid_o,
    output logic [ADDR_W-1:0] s_ar_addr_o,
    input  logic              s_ar_ready_i,
    input  logic              s_r_valid_i,
    input  logic [DATA_W-1:0] s_r_data_i,
    input  logic [1:0]        s_r_resp_i,
    output logic              s_r_ready_o,
    output logic              s_aw_valid_o,
    output logic [ADDR_W-1:0] s_aw_addr_o,
    input  logic              s_aw_ready_i,
    output logic              s_w_valid_o,
    output logic [DATA_W-1:0] s_w_data_o,
    output logic [STRB_W-1:0] s_w_strb_o,
    input  logic              s_w_ready_i,
    input  logic              s_b_valid_i,
    input  logic [1:0]        s_b_resp_i,
    output logic              s_b_ready_o
);

    localparam logic [1:0] RespOkay = 2'b00;

    localparam logic [3:0] StIdle = 4'b0001;
    localparam logic [3:0] StRdM0 = 4'b0010;
    localparam logic [3:0] StRdM1 = 4'b0100;
    localparam logic [3:0] StWrM1 = 4'b1000;

    logic [3:0] state_q, state_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       last_q, last_d;      // 0: M0 granted most recently, 1: M1

    logic       m0_req, m1_req, m1_wins;
    logic [3:0] m1_st;

    assign m0_req = m0_ar_valid_i;
    assign m1_req = m1_ar_valid_i | m1_aw_valid_i;
    // M1 read takes precedence over M1 write
    assign m1_st  = m1_ar_valid_i ? StRdM1 : StWrM1;

`ifdef AXI_ARB_RR_EN
    assign m1_wins = ~last_q;
`else
    logic unused_last;
    assign m1_wins     = 1'b1;
    assign unused_last = last_q;
`endif

    // Arbitration, handshake bookkeeping and grant release
    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        last_d    = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req && m1_req) begin
                    state_d = m1_wins ? m1_st : StRdM0;
                end else if (m1_req) begin
                    state_d = m1_st;
                end else if (m0_req) begin
                    state_d = StRdM0;
                end
            end
            StRdM0: begin
                if (m0_ar_valid_i && s_ar_ready_i && !ar_done_q) ar_done_d = 1'b1;
                if (s_r_valid_i && m0_r_ready_i) begin
                    state_d   = StIdle;
                    ar_done_d = 1'b0;
                    last_d    = 1'b0;
                end
            end
            StRdM1: begin
                if (m1_ar_valid_i && s_ar_ready_i && !ar_done_q) ar_done_d = 1'b1;
                if (s_r_valid_i && m1_r_ready_i) begin
                    state_d   = StIdle;
                    ar_done_d = 1'b0;
                    last_d    = 1'b1;
                end
            end
            StWrM1: begin
                if (m1_aw_valid_i && s_aw_ready_i && !aw_done_q) aw_done_d = 1'b1;
                if (m1_w_valid_i && s_w_ready_i && !w_done_q) w_done_d = 1'b1;
                if (s_b_valid_i && m1_b_ready_i) begin
                    state_d   = StIdle;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    last_d    = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // Channel routing: only the granted master sees the slave, everything else idles at zero
    always_comb begin
        m0_ar_ready_o = 1'b0;
        m0_r_valid_o  = 1'b0;
        m0_r_data_o   = '0;
        m0_r_resp_o   = RespOkay;
        m1_ar_ready_o = 1'b0;
        m1_r_valid_o  = 1'b0;
        m1_r_data_o   = '0;
        m1_r_resp_o   = RespOkay;
        m1_aw_ready_o = 1'b0;
        m1_w_ready_o  = 1'b0;
        m1_b_valid_o  = 1'b0;
        m1_b_resp_o   = RespOkay;
        s_ar_valid_o  = 1'b0;
        s_ar_addr_o   = '0;
        s_r_ready_o   = 1'b0;
        s_aw_valid_o  = 1'b0;
        s_aw_addr_o   = '0;
        s_w_valid_o   = 1'b0;
        s_w_data_o    = '0;
        s_w_strb_o    = '0;
        s_b_ready_o   = 1'b0;
        unique case (state_q)
            StRdM0: begin
                s_ar_valid_o  = m0_ar_valid_i & ~ar_done_q;
                s_ar_addr_o   = m0_ar_addr_i;
                m0_ar_ready_o = s_ar_ready_i & ~ar_done_q;
                m0_r_valid_o  = s_r_valid_i;
                m0_r_data_o   = s_r_data_i;
                m0_r_resp_o   = s_r_resp_i;
                s_r_ready_o   = m0_r_ready_i;
            end
            StRdM1: begin
                s_ar_valid_o  = m1_ar_valid_i & ~ar_done_q;
                s_ar_addr_o   = m1_ar_addr_i;
                m1_ar_ready_o = s_ar_ready_i & ~ar_done_q;
                m1_r_valid_o  = s_r_valid_i;
                m1_r_data_o   = s_r_data_i;
                m1_r_resp_o   = s_r_resp_i;
                s_r_ready_o   = m1_r_ready_i;
            end
            StWrM1: begin
                s_aw_valid_o  = m1_aw_valid_i & ~aw_done_q;
                s_aw_addr_o   = m1_aw_addr_i;
                m1_aw_ready_o = s_aw_ready_i & ~aw_done_q;
                s_w_valid_o   = m1_w_valid_i & ~w_done_q;
                s_w_data_o    = m1_w_data_i;
                s_w_strb_o    = m1_w_strb_i;
                m1_w_ready_o  = s_w_ready_i & ~w_done_q;
                m1_b_valid_o  = s_b_valid_i;
                m1_b_resp_o   = s_b_resp_i;
                s_b_ready_o   = m1_b_ready_i;
            end
            default: ;
        endcase
    end

    // State and flag registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter; expected values are hand-derived per step.
module tb_axi_lite_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_ar_valid_i, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i;
    logic [AW-1:0] m0_ar_addr_i;
    logic [DW-1:0] m0_r_data_o;
    logic [1:0]    m0_r_resp_o;
    logic          m1_ar_valid_i, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i;
    logic [AW-1:0] m1_ar_addr_i, m1_aw_addr_i;
    logic [DW-1:0] m1_r_data_o, m1_w_data_i;
    logic [1:0]    m1_r_resp_o, m1_b_resp_o;
    logic          m1_aw_valid_i, m1_aw_ready_o, m1_w_valid_i, m1_w_ready_o;
    logic [SW-1:0] m1_w_strb_i;
    logic          m1_b_valid_o, m1_b_ready_i;
    logic          s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o;
    logic [AW-1:0] s_ar_addr_o, s_aw_addr_o;
    logic [DW-1:0] s_r_data_i, s_w_data_o;
    logic [1:0]    s_r_resp_i, s_b_resp_i;
    logic          s_aw_valid_o, s_aw_ready_i, s_w_valid_o, s_w_ready_i;
    logic [SW-1:0] s_w_strb_o;
    logic          s_b_valid_i, s_b_ready_o;

    int n_vec = 0;
    int n_err = 0;
    int aw_hs = 0;
    int w_hs  = 0;

    axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_ready_o(m0_ar_ready_o),
        .m0_r_valid_o(m0_r_valid_o), .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o),
        .m0_r_ready_i(m0_r_ready_i),
        .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_ready_o(m1_ar_ready_o),
        .m1_r_valid_o(m1_r_valid_o), .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o),
        .m1_r_ready_i(m1_r_ready_i),
        .m1_aw_valid_i(m1_aw_valid_i), .m1_aw_addr_i(m1_aw_addr_i), .m1_aw_ready_o(m1_aw_ready_o),
        .m1_w_valid_i(m1_w_valid_i), .m1_w_data_i(m1_w_data_i), .m1_w_strb_i(m1_w_strb_i),
        .m1_w_ready_o(m1_w_ready_o),
        .m1_b_valid_o(m1_b_valid_o), .m1_b_resp_o(m1_b_resp_o), .m1_b_ready_i(m1_b_ready_i),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
        .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i),
        .s_r_ready_o(s_r_ready_o),
        .s_aw_valid_o(s_aw_valid_o), .s_aw_addr_o(s_aw_addr_o), .s_aw_ready_i(s_aw_ready_i),
        .s_w_valid_o(s_w_valid_o), .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o),
        .s_w_ready_i(s_w_ready_i),
        .s_b_valid_i(s_b_valid_i), .s_b_resp_i(s_b_resp_i), .s_b_ready_o(s_b_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Count slave-side AW/W handshakes, sampled with pre-edge values
    always @(posedge clk_i) begin
        if (s_aw_valid_o && s_aw_ready_i) aw_hs <= aw_hs + 1;
        if (s_w_valid_o && s_w_ready_i) w_hs <= w_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_ar_valid_i = 0; m0_ar_addr_i = '0; m0_r_ready_i = 0;
        m1_ar_valid_i = 0; m1_ar_addr_i = '0; m1_r_ready_i = 0;
        m1_aw_valid_i = 0; m1_aw_addr_i = '0; m1_w_valid_i = 0;
        m1_w_data_i = '0; m1_w_strb_i = '0; m1_b_ready_i = 0;
        s_ar_ready_i = 0; s_r_valid_i = 0; s_r_data_i = '0; s_r_resp_i = 2'b00;
        s_aw_ready_i = 0; s_w_ready_i = 0; s_b_valid_i = 0; s_b_resp_i = 2'b00;
    endtask

    logic [AW-1:0] exp_addr2;
    logic          exp_m0_wins2;

    initial begin
`ifdef AXI_ARB_RR_EN
        exp_addr2    = 32'h0000_0100;
        exp_m0_wins2 = 1'b1;
`else
        exp_addr2    = 32'h0000_0200;
        exp_m0_wins2 = 1'b0;
`endif
        clear_inputs();
        rst_i = 0;
        tick(); tick();

        // Reset state
        settle();
        chk("rst_m0_ar_ready", 64'(m0_ar_ready_o), 64'd0);
        chk("rst_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
        chk("rst_s_aw_addr", 64'(s_aw_addr_o), 64'd0);
        chk("rst_m0_r_resp", 64'(m0_r_resp_o), 64'd0);
        chk("rst_m1_b_valid", 64'(m1_b_valid_o), 64'd0);
        rst_i = 1;

        // Single M0 read
        tick();
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0000; s_ar_ready_i = 1; m0_r_ready_i = 1;
        settle();
        chk("m0rd_idle_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
        chk("m0rd_idle_ar_ready", 64'(m0_ar_ready_o), 64'd0);
        tick();
        chk("m0rd_s_ar_valid", 64'(s_ar_valid_o), 64'd1);
        chk("m0rd_s_ar_addr", 64'(s_ar_addr_o), 64'h8000_0000);
        chk("m0rd_ar_ready", 64'(m0_ar_ready_o), 64'd1);
        tick();
        m0_ar_valid_i = 0; s_r_valid_i = 1; s_r_data_i = 32'hDEAD_BEEF;
        settle();
        chk("m0rd_ar_done", 64'(s_ar_valid_o), 64'd0);
        chk("m0rd_r_valid", 64'(m0_r_valid_o), 64'd1);
        chk("m0rd_r_data", 64'(m0_r_data_o), 64'hDEAD_BEEF);
        chk("m0rd_r_resp", 64'(m0_r_resp_o), 64'd0);
        chk("m0rd_m1_r_valid", 64'(m1_r_valid_o), 64'd0);
        chk("m0rd_s_r_ready", 64'(s_r_ready_o), 64'd1);
        tick();
        clear_inputs();
        settle();
        chk("m0rd_back_idle", 64'(m0_r_valid_o), 64'd0);

        // M1 write with AW stalled 3 cycles while W is accepted at once
        tick();
        m1_aw_valid_i = 1; m1_aw_addr_i = 32'h8000_0010;
        m1_w_valid_i = 1; m1_w_data_i = 32'h1234_5678; m1_w_strb_i = 4'b0011;
        s_w_ready_i = 1; m1_b_ready_i = 1;
        tick();
        chk("wr_s_aw_valid", 64'(s_aw_valid_o), 64'd1);
        chk("wr_s_aw_addr", 64'(s_aw_addr_o), 64'h8000_0010);
        chk("wr_s_w_valid", 64'(s_w_valid_o), 64'd1);
        chk("wr_s_w_data", 64'(s_w_data_o), 64'h1234_5678);
        chk("wr_s_w_strb", 64'(s_w_strb_o), 64'h3);
        chk("wr_aw_ready_lo", 64'(m1_aw_ready_o), 64'd0);
        chk("wr_w_ready", 64'(m1_w_ready_o), 64'd1);
        tick();
        m1_w_valid_i = 0;
        settle();
        chk("wr_w_done", 64'(s_w_valid_o), 64'd0);
        chk("wr_aw_pending", 64'(s_aw_valid_o), 64'd1);
        tick();
        tick();
        s_aw_ready_i = 1;
        settle();
        chk("wr_aw_ready_hi", 64'(m1_aw_ready_o), 64'd1);
        tick();
        m1_aw_valid_i = 0; s_aw_ready_i = 0;
        settle();
        chk("wr_aw_done", 64'(s_aw_valid_o), 64'd0);
        chk("wr_b_before", 64'(m1_b_valid_o), 64'd0);
        s_b_valid_i = 1;
        settle();
        chk("wr_b_valid", 64'(m1_b_valid_o), 64'd1);
        chk("wr_s_b_ready", 64'(s_b_ready_o), 64'd1);
        tick();
        clear_inputs();
        settle();
        chk("wr_aw_count", 64'(aw_hs), 64'd1);
        chk("wr_w_count", 64'(w_hs), 64'd1);
        chk("wr_idle_b_valid", 64'(m1_b_valid_o), 64'd0);

        // Contention from reset, then repeated
        rst_i = 0;
        tick();
        rst_i = 1;
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h0000_0100;
        m1_ar_valid_i = 1; m1_ar_addr_i = 32'h0000_0200;
        s_ar_ready_i = 1; m0_r_ready_i = 1; m1_r_ready_i = 1;
        tick();
        chk("arb1_s_ar_addr", 64'(s_ar_addr_o), 64'h0000_0200);
        chk("arb1_m1_ar_ready", 64'(m1_ar_ready_o), 64'd1);
        chk("arb1_m0_ar_ready", 64'(m0_ar_ready_o), 64'd0);
        tick();
        m1_ar_valid_i = 0; s_r_valid_i = 1; s_r_data_i = 32'h11;
        settle();
        chk("arb1_m1_r_valid", 64'(m1_r_valid_o), 64'd1);
        chk("arb1_m0_r_valid", 64'(m0_r_valid_o), 64'd0);
        tick();
        s_r_valid_i = 0; m1_ar_valid_i = 1;
        settle();
        chk("arb2_idle", 64'(s_ar_valid_o), 64'd0);
        tick();
        chk("arb2_s_ar_addr", 64'(s_ar_addr_o), 64'(exp_addr2));
        chk("arb2_m0_ar_ready", 64'(m0_ar_ready_o), 64'(exp_m0_wins2));
        tick();
        if (exp_m0_wins2) m0_ar_valid_i = 0;
        else m1_ar_valid_i = 0;
        s_r_valid_i = 1; s_r_data_i = 32'h22;
        settle();
        chk("arb2_m0_r_valid", 64'(m0_r_valid_o), 64'(exp_m0_wins2));
        chk("arb2_m1_r_valid", 64'(m1_r_valid_o), 64'(!exp_m0_wins2));
        tick();
        clear_inputs();

        // Back-to-back M1 reads, slave latency 0
        tick();
        m1_ar_valid_i = 1; m1_ar_addr_i = 32'h0000_0A00; s_ar_ready_i = 1; m1_r_ready_i = 1;
        tick();
        chk("b2b_first_ar", 64'(s_ar_valid_o), 64'd1);
        tick();
        m1_ar_addr_i = 32'h0000_0B00; s_r_valid_i = 1; s_r_data_i = 32'h33;
        settle();
        chk("b2b_ar_gated", 64'(s_ar_valid_o), 64'd0);
        chk("b2b_r_valid", 64'(m1_r_valid_o), 64'd1);
        tick();
        s_r_valid_i = 0;
        settle();
        chk("b2b_n_plus_1", 64'(s_ar_valid_o), 64'd0);
        tick();
        chk("b2b_n_plus_2", 64'(s_ar_valid_o), 64'd1);
        chk("b2b_addr2", 64'(s_ar_addr_o), 64'h0000_0B00);
        tick();
        m1_ar_valid_i = 0; s_r_valid_i = 1;
        tick();
        clear_inputs();

        // Reset during RD_M0 after the AR handshake
        tick();
        m0_ar_valid_i = 1; m0_ar_addr_i = 32'h0000_0C00; s_ar_ready_i = 1; m0_r_ready_i = 1;
        tick();
        tick();
        m0_ar_valid_i = 0;
        rst_i = 0;
        settle();
        chk("rstmid_pre_r_valid", 64'(m0_r_valid_o), 64'd0);
        tick();
        rst_i = 1; s_r_valid_i = 1; s_r_data_i = 32'h44;
        settle();
        chk("rstmid_m0_r_valid", 64'(m0_r_valid_o), 64'd0);
        chk("rstmid_s_r_ready", 64'(s_r_ready_o), 64'd0);
        chk("rstmid_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
        tick();
        chk("rstmid_m0_r_valid2", 64'(m0_r_valid_o), 64'd0);
        clear_inputs();

        // Spurious slave B response in IDLE
        tick();
        s_b_valid_i = 1;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("spur_m1_b_valid", 64'(m1_b_valid_o), 64'd0);
            chk("spur_s_b_ready", 64'(s_b_ready_o), 64'd0);
            chk("spur_s_aw_valid", 64'(s_aw_valid_o), 64'd0);
            tick();
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
